// File: rtl/dsp_filters_pkg.sv
// Shared definitions for the sample-strobe DSP filters.
// State codes and width helpers.
package dsp_filters_pkg;

  localparam logic [1:0] ST_UNPRIMED = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_EMIT     = 2'd2;

  function automatic int acc_width(
    input int dw,
    input int lf
  );
    return dw + 1 + lf;
  endfunction

endpackage

// File: rtl/interp_step_acc.sv
// Interpolation accumulator: load base<<LOG2_FACTOR, add diff per step.
// Ports: clk, reset_n, load, step, base, diff -> y (acc>>>LOG2_FACTOR).
import dsp_filters_pkg::*;

module interp_step_acc #(
  parameter int DATA_WIDTH  = 8,
  parameter int LOG2_FACTOR = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [DATA_WIDTH:0]   diff,
  output logic [DATA_WIDTH-1:0] y
);

  localparam int AW = acc_width(DATA_WIDTH, LOG2_FACTOR);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] base_ext;
  logic signed [AW-1:0] diff_ext;

  assign base_ext = AW'($signed(base)) <<< LOG2_FACTOR;
  assign diff_ext = AW'($signed(diff));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= base_ext;
    end else if (step) begin
      acc <= acc + diff_ext;
    end
  end

  // Value always lies between base and x[n], so this slice is exact.
  assign y = acc[LOG2_FACTOR +: DATA_WIDTH];

endmodule

// File: rtl/linear_interpolator.sv
// Signed linear-interpolating upsampler by L = 2^LOG2_FACTOR.
// Ports: clk, reset_n, i_ce, data_in -> o_ready, data_out, o_ce, o_drop.
import dsp_filters_pkg::*;

module linear_interpolator #(
  parameter int DATA_WIDTH  = 8,
  parameter int LOG2_FACTOR = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_ce,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  o_ce,
  output logic                  o_drop
);

  localparam int L  = 1 << LOG2_FACTOR;
  localparam int KW = (LOG2_FACTOR > 0) ? LOG2_FACTOR : 1;
  localparam logic [KW-1:0] K_LAST = KW'(L - 1);

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH:0]   diff_next;
  logic [KW-1:0]         k;
  logic                  accept;
  logic                  load;
  logic                  step;

  assign o_ready   = (state != ST_EMIT);
  assign accept    = i_ce & o_ready;
  assign load      = accept & (state == ST_IDLE);
  assign step      = (state == ST_EMIT);
  assign diff_next = {data_in[DATA_WIDTH-1], data_in}
                   - {prev[DATA_WIDTH-1], prev};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_UNPRIMED;
      prev   <= '0;
      diff   <= '0;
      k      <= '0;
      o_ce   <= 1'b0;
      o_drop <= 1'b0;
    end else begin
      o_ce   <= 1'b0;
      o_drop <= i_ce & ~o_ready;
      unique case (1'b1)
        (state == ST_UNPRIMED): begin
          if (accept) begin
            prev  <= data_in;
            state <= ST_IDLE;
          end
        end
        (state == ST_IDLE): begin
          if (accept) begin
            diff <= diff_next;
            prev <= data_in;
            k    <= KW'(1);
            o_ce <= 1'b1;
            if (L > 1) state <= ST_EMIT;
          end
        end
        (state == ST_EMIT): begin
          o_ce <= 1'b1;
          k    <= k + KW'(1);
          if (k == K_LAST) state <= ST_IDLE;
        end
        default: state <= ST_UNPRIMED;
      endcase
    end
  end

  // Accumulator register drives data_out directly (y0 loaded at accept).
  interp_step_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG2_FACTOR(LOG2_FACTOR)
  ) u_acc (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (load),
    .step   (step),
    .base   (prev),
    .diff   (diff),
    .y      (data_out)
  );

endmodule

// File: doc/linear_interpolator.md
# linear_interpolator

Signed linear-interpolating upsampler by L = 2^LOG2_FACTOR. It is the rate-increasing counterpart of the two-tap averaging filter: it accepts one sample per strobe and emits L evenly spaced points from the previous sample toward the current one. It sits on the same i_ce/o_ce sample-strobe bus as the other filters in the codebase. Because output rate exceeds input rate, it provides an o_ready backpressure signal.

## Interface
- DATA_WIDTH, 8: sample width, two's complement.
- LOG2_FACTOR, 2: log2 of the upsample factor L; legal range 0..4.
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- i_ce  in  1  input sample strobe; accepted only when o_ready=1.
- data_in  in  DATA_WIDTH  signed input sample.
- o_ready  out  1  block can accept a sample this cycle; decoded from state registers only, with no input path.
- data_out  out  DATA_WIDTH  signed interpolated sample, registered.
- o_ce  out  1  data_out valid, registered.
- o_drop  out  1  one-cycle pulse when i_ce=1 arrives while o_ready=0; the sample is discarded.

## Operation
- States:
  - UNPRIMED: reset state; no history.
  - IDLE: primed, waiting.
  - EMIT: outputs in flight.
- UNPRIMED + accept:
  - prev <= data_in; go to IDLE.
  - No output.
- IDLE + accept of x[n]:
  - base <= prev; diff <= x[n] - prev (DATA_WIDTH+1 bits); prev <= x[n].
  - Emit y0 = base at this edge; k <= 1.
  - Go to EMIT if L>1, else remain in IDLE.
- EMIT, one output per cycle:
  - y_k = (base*L + k*diff) >>> LOG2_FACTOR, i.e. the arithmetic shift gives floor(base + k*diff/L).
  - Accumulator width is DATA_WIDTH+1+LOG2_FACTOR; it steps by diff each cycle, with no multiplier.
  - The result always lies between base and x[n], so truncation to DATA_WIDTH is exact; no saturation logic is needed.
- Transitions:
  - EMIT ends when y_{L-1} is registered (k==L-1); next state is IDLE.
  - o_ready = (state != EMIT).
  - i_ce while o_ready=0 pulses o_drop and changes no other state.
- Synchronous reset, including mid-EMIT:
  - Next edge: state=UNPRIMED, prev/base/diff/k=0.
  - Outputs: data_out=0, o_ce=0, o_drop=0, o_ready=1.
  - Pending outputs are abandoned.

## Timing
- Acceptance edge E0 registers y0; y_k appears after edge E_k for k=0..L-1.
- Latency: one clock from acceptance to first valid output.
- o_ce is high for exactly L consecutive cycles per accepted sample (after UNPRIMED).
- o_ready rises in the cycle displaying y_{L-1}, so the next accept can occur at edge E_L.
- With i_ce every L cycles, o_ce stays continuously high.
- If no accept occurs at E_L, o_ce drops to 0 and data_out holds its last value.
- LOG2_FACTOR=0 (L=1): o_ready is permanently 1 after reset; each accept emits the previous sample. The block acts as a one-sample delay with o_ce lagging by one edge.
- The priming sample never produces output.

## Structure
- Shared package/header `dsp_filters_pkg` holds:
  - the state encoding localparams (UNPRIMED, IDLE, EMIT);
  - a width helper for the accumulator width DATA_WIDTH+1+LOG2_FACTOR.
- One natural sub-module, `interp_step_acc`:
  - loads base<<LOG2_FACTOR, adds diff on each step;
  - outputs acc>>>LOG2_FACTOR.
- FSM, counter k, and handshake stay in the top module.

## Test plan
- Reset values and priming: reset, then accept 10.
  - Required: no o_ce; o_ready stays 1; all outputs 0 during reset.
- Ramp up, L=4: prime 10, then accept 30.
  - Required: 10, 15, 20, 25 on four consecutive o_ce cycles; o_ready low for three cycles.
- Ramp down: continue with -10.
  - Required: 30, 20, 10, 0.
- Floor rounding and extremes:
  - After prime 0, accept 1: required 0, 0, 0, 0.
  - After prime -1, accept 0: required -1, -1, -1, -1.
  - After prime -128, accept 127: required -128, -65, -1, 63.
- Backpressure and continuity:
  - i_ce asserted in the cycle after E0: required o_drop pulse, output sequence unchanged.
  - Inputs every 4 cycles: required o_ce continuously high with no gap.
- Reset mid-EMIT: assert reset_n=0 after y1.
  - Required next edge: o_ce=0, data_out=0, state UNPRIMED.
  - The next accepted sample only primes.
